// File: rtl/round_ctrl.sv
// Purpose : typing-tutor round controller; sequences IDLE->ARM->RUN->DONE, scores keys, drives timer.
// Latency : all outputs registered; a key scored on cycle N is visible in the counters on cycle N+1.
// Backpr. : none; key_valid is a per-cycle strobe, so a key held high is scored once per cycle.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             round start request (honoured in IDLE and DONE only)
//   time_left         remaining time from the timer; zero means expired
//   key_valid/code    keystroke strobe and its ASCII code
//   expected_code     target character at char_idx (text ROM data)
//   timer_en/clr      timer count enable (RUN) and one-cycle reload pulse (ARM)
//   char_idx          text ROM address of the next expected character
//   correct_cnt       saturating count of matching keystrokes
//   error_cnt         saturating count of mismatching keystrokes
//   state, done       current state (IDLE=0 ARM=1 RUN=2 DONE=3), level high in DONE
module round_ctrl #(
    parameter int TIME_W   = 4,
    parameter int SCORE_W  = 8,
    parameter int IDX_W    = 6,
    parameter int TEXT_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TIME_W-1:0]  time_left,
    input  logic               key_valid,
    input  logic [7:0]         key_code,
    input  logic [7:0]         expected_code,
    output logic               timer_en,
    output logic               timer_clr,
    output logic [IDX_W-1:0]   char_idx,
    output logic [SCORE_W-1:0] correct_cnt,
    output logic [SCORE_W-1:0] error_cnt,
    output logic [1:0]         state,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(TEXT_LEN);

    state_t             r_state;
    logic               r_timer_en;
    logic               r_timer_clr;
    logic               r_done;
    logic [IDX_W-1:0]   r_char_idx;
    logic [SCORE_W-1:0] r_correct_cnt;
    logic [SCORE_W-1:0] r_error_cnt;

    logic               w_expired;
    logic               w_match;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [SCORE_W-1:0] w_correct_nxt;
    logic [SCORE_W-1:0] w_error_nxt;

    assign w_expired     = (time_left == '0);
    assign w_match       = (key_code == expected_code);
    assign w_idx_nxt     = r_char_idx + 1'b1;
    // Counters stick at all-ones instead of wrapping back to zero.
    assign w_correct_nxt = (r_correct_cnt == SCORE_MAX) ? r_correct_cnt : r_correct_cnt + 1'b1;
    assign w_error_nxt   = (r_error_cnt   == SCORE_MAX) ? r_error_cnt   : r_error_cnt   + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_timer_en    <= 1'b0;
            r_timer_clr   <= 1'b0;
            r_done        <= 1'b0;
            r_char_idx    <= '0;
            r_correct_cnt <= '0;
            r_error_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A new round wipes the previous score on the same edge it arms the timer.
                    if (start) begin
                        r_state       <= ST_ARM;
                        r_timer_clr   <= 1'b1;
                        r_done        <= 1'b0;
                        r_char_idx    <= '0;
                        r_correct_cnt <= '0;
                        r_error_cnt   <= '0;
                    end
                end
                ST_ARM: begin
                    r_state     <= ST_RUN;
                    r_timer_clr <= 1'b0;
                    r_timer_en  <= 1'b1;
                end
                ST_RUN: begin
                    // Expiry wins over a key arriving in the same cycle; that key is dropped.
                    if (w_expired) begin
                        r_state    <= ST_DONE;
                        r_timer_en <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (key_valid) begin
                        if (w_match) begin
                            r_correct_cnt <= w_correct_nxt;
                            r_char_idx    <= w_idx_nxt;
                            // char_idx tracks characters completed, so it decides text end
                            // even when a narrow correct_cnt has already saturated.
                            if (w_idx_nxt == IDX_LAST) begin
                                r_state    <= ST_DONE;
                                r_timer_en <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end else begin
                            r_error_cnt <= w_error_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign timer_en    = r_timer_en;
    assign timer_clr   = r_timer_clr;
    assign done        = r_done;
    assign char_idx    = r_char_idx;
    assign correct_cnt = r_correct_cnt;
    assign error_cnt   = r_error_cnt;
    assign state       = r_state;

endmodule

// File: tb/tb_round_ctrl.sv
// Purpose : checks round_ctrl (default build and a TEXT_LEN=4 / SCORE_W=2 build) against a behavioural model.
// Latency : model updates on the same clock edge as the DUT; outputs compared on every falling edge.
// Backpr. : none; both DUTs share one stimulus stream.
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] time_left;
    logic       key_valid;
    logic [7:0] key_code;
    logic [7:0] expected_code;

    // Instance A: default parameters.
    logic       a_timer_en, a_timer_clr, a_done;
    logic [5:0] a_char_idx;
    logic [7:0] a_correct_cnt, a_error_cnt;
    logic [1:0] a_state;

    // Instance B: short text and narrow counters to reach the boundaries quickly.
    logic       b_timer_en, b_timer_clr, b_done;
    logic [5:0] b_char_idx;
    logic [1:0] b_correct_cnt, b_error_cnt;
    logic [1:0] b_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    round_ctrl #(.TIME_W(4), .SCORE_W(8), .IDX_W(6), .TEXT_LEN(32)) dut_a (
        .clk(clk), .reset(reset), .start(start), .time_left(time_left),
        .key_valid(key_valid), .key_code(key_code), .expected_code(expected_code),
        .timer_en(a_timer_en), .timer_clr(a_timer_clr), .char_idx(a_char_idx),
        .correct_cnt(a_correct_cnt), .error_cnt(a_error_cnt),
        .state(a_state), .done(a_done)
    );

    round_ctrl #(.TIME_W(4), .SCORE_W(2), .IDX_W(6), .TEXT_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .time_left(time_left),
        .key_valid(key_valid), .key_code(key_code), .expected_code(expected_code),
        .timer_en(b_timer_en), .timer_clr(b_timer_clr), .char_idx(b_char_idx),
        .correct_cnt(b_correct_cnt), .error_cnt(b_error_cnt),
        .state(b_state), .done(b_done)
    );

    // ---------------- behavioural model ----------------
    // Round phase 0..3, plus plain integer scores; flags are derived from the phase.
    int m_phase [2] = '{0, 0};
    int m_corr  [2] = '{0, 0};
    int m_err   [2] = '{0, 0};
    int m_idx   [2] = '{0, 0};
    int m_tlen  [2] = '{32, 4};
    int m_smax  [2] = '{255, 3};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_corr[k] = 0; m_err[k] = 0; m_idx[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_phase[k] == 0 || m_phase[k] == 3) begin
                    if (start) begin
                        m_phase[k] = 1; m_corr[k] = 0; m_err[k] = 0; m_idx[k] = 0;
                    end
                end else if (m_phase[k] == 1) begin
                    m_phase[k] = 2;
                end else begin
                    if (time_left == 0) m_phase[k] = 3;
                    else if (key_valid && key_code == expected_code) begin
                        if (m_corr[k] < m_smax[k]) m_corr[k] = m_corr[k] + 1;
                        m_idx[k] = m_idx[k] + 1;
                        if (m_idx[k] >= m_tlen[k]) m_phase[k] = 3;
                    end else if (key_valid) begin
                        if (m_err[k] < m_smax[k]) m_err[k] = m_err[k] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("A.state",     int'(a_state),       m_phase[0]);
        chk("A.timer_en",  int'(a_timer_en),    int'(m_phase[0] == 2));
        chk("A.timer_clr", int'(a_timer_clr),   int'(m_phase[0] == 1));
        chk("A.done",      int'(a_done),        int'(m_phase[0] == 3));
        chk("A.char_idx",  int'(a_char_idx),    m_idx[0]);
        chk("A.correct",   int'(a_correct_cnt), m_corr[0]);
        chk("A.error",     int'(a_error_cnt),   m_err[0]);
        chk("B.state",     int'(b_state),       m_phase[1]);
        chk("B.timer_en",  int'(b_timer_en),    int'(m_phase[1] == 2));
        chk("B.timer_clr", int'(b_timer_clr),   int'(m_phase[1] == 1));
        chk("B.done",      int'(b_done),        int'(m_phase[1] == 3));
        chk("B.char_idx",  int'(b_char_idx),    m_idx[1]);
        chk("B.correct",   int'(b_correct_cnt), m_corr[1]);
        chk("B.error",     int'(b_error_cnt),   m_err[1]);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; time_left = 4'd9;
        key_valid = 1'b0; key_code = 8'h00; expected_code = 8'h61;
        #1 reset = 1'b0;
        tick(); tick();
        chk("lit reset state", int'(a_state), 0);
        chk("lit reset cnt",   int'(a_correct_cnt) + int'(a_error_cnt) + int'(a_char_idx), 0);
        reset = 1'b1;
        tick();

        // Round start: ARM for one cycle with timer reload, then RUN with timer enabled.
        pulse_start();
        chk("lit arm state",   int'(a_state), 1);
        chk("lit arm clr",     int'(a_timer_clr), 1);
        chk("lit arm en",      int'(a_timer_en), 0);
        tick();
        chk("lit run state",   int'(a_state), 2);
        chk("lit run en",      int'(a_timer_en), 1);
        chk("lit run clr",     int'(a_timer_clr), 0);

        // Mixed scoring against 'a'.
        key(8'h61); key(8'h62); key(8'h61);
        chk("lit mix correct", int'(a_correct_cnt), 2);
        chk("lit mix error",   int'(a_error_cnt), 1);
        chk("lit mix idx",     int'(a_char_idx), 2);
        key(8'h41);  // 'A' is not 'a'
        chk("lit case error",  int'(a_error_cnt), 2);

        // Asynchronous reset in the middle of RUN.
        #2 reset = 1'b0;
        #1;
        chk("lit async state", int'(a_state), 0);
        chk("lit async en",    int'(a_timer_en), 0);
        chk("lit async cnt",   int'(a_correct_cnt) + int'(a_error_cnt) + int'(a_char_idx), 0);
        tick();
        reset = 1'b1;
        tick();

        // Text end on the short build: four matches finish the round.
        pulse_start(); tick();
        key(8'h61); key(8'h61); key(8'h61);
        chk("lit B not yet done", int'(b_done), 0);
        key(8'h61);
        chk("lit B done",      int'(b_done), 1);
        chk("lit B en off",    int'(b_timer_en), 0);
        chk("lit B idx",       int'(b_char_idx), 4);
        chk("lit B corr sat",  int'(b_correct_cnt), 3);
        key(8'h61); key(8'h62);
        chk("lit B held idx",  int'(b_char_idx), 4);
        chk("lit B held err",  int'(b_error_cnt), 0);
        chk("lit A still run", int'(a_correct_cnt), 5);

        // start re-arms B from DONE; A ignores it in RUN.
        pulse_start();
        chk("lit B rearm",     int'(b_state), 1);
        chk("lit A ignores",   int'(a_state), 2);
        tick();
        repeat (5) key(8'h7a);
        chk("lit B err sat",   int'(b_error_cnt), 3);
        chk("lit A err",       int'(a_error_cnt), 6);

        // Expiry with a matching key in the same cycle: key dropped.
        time_left = 4'd0;
        key(8'h61);
        chk("lit exp state",   int'(a_state), 3);
        chk("lit exp corr",    int'(a_correct_cnt), 5);
        chk("lit exp B idx",   int'(b_char_idx), 0);
        time_left = 4'd9;
        tick();
        pulse_start();
        chk("lit new round",   int'(a_state), 1);
        chk("lit new clear",   int'(a_correct_cnt) + int'(a_error_cnt) + int'(a_char_idx), 0);
        tick();
        key(8'h61);
        chk("lit new corr",    int'(a_correct_cnt), 1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
